// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline stall/flush scheduler: FSM states, stage indices
// and the packed per-stage control vectors.
package pipe_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_RUN        = 3'd0,
        ST_MEM_WAIT   = 3'd1,
        ST_HALT_DRAIN = 3'd2,
        ST_HALTED     = 3'd3,
        ST_FAULT      = 3'd4
    } state_e;

    localparam int unsigned STG_F   = 0;
    localparam int unsigned STG_D   = 1;
    localparam int unsigned STG_E   = 2;
    localparam int unsigned STG_M   = 3;
    localparam int unsigned STG_WB  = 4;
    localparam int unsigned NUM_STG = 5;

    typedef logic [NUM_STG-1:0] stage_vec_t;

    // F is never flushed, so the flush field only covers D..WB
    typedef struct packed {
        stage_vec_t          stall;
        logic [STG_WB:STG_D] flush;
    } pipe_ctl_t;

    localparam stage_vec_t STALL_MEM = 5'b01111;
    localparam stage_vec_t STALL_ALL = 5'b11111;

endpackage

// File: rtl/pipe_ctrl_perf.sv
// Saturating performance counters: cycles with stall_F held, and jump flushes.
// Instantiated by pipeline_ctrl only when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl_perf
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             stall_f,
    input  logic             jump_flush,
    output logic [CNT_W-1:0] perf_stall_cnt,
    output logic [CNT_W-1:0] perf_flush_cnt
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (stall_f && !(&perf_stall_cnt)) begin
                perf_stall_cnt <= perf_stall_cnt + CNT_W'(1);
            end
            if (jump_flush && !(&perf_flush_cnt)) begin
                perf_flush_cnt <= perf_flush_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush scheduler for the F/D/E/M/WB pipeline.
// Optional perf counters are enabled by defining PIPE_CTRL_PERF_EN.
module pipeline_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned HALT_DRAIN  = 3,
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             hz_stall_req,
    input  logic             jump_req,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    input  logic             halt_req,
    input  logic             resume,
    output logic             stall_F,
    output logic             stall_D,
    output logic             stall_E,
    output logic             stall_M,
    output logic             stall_WB,
    output logic             flush_D,
    output logic             flush_E,
    output logic             flush_M,
    output logic             flush_WB,
    output logic             halted,
    output logic             fault,
    output logic [2:0]       state
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [CNT_W-1:0] perf_stall_cnt,
    output logic [CNT_W-1:0] perf_flush_cnt
`endif
);

    localparam int unsigned         TMO_W     = $clog2(MEM_TIMEOUT + 2);
    localparam logic [TMO_W-1:0]    TMO_LIM   = TMO_W'(MEM_TIMEOUT);
    localparam bit                  TMO_EN    = (MEM_TIMEOUT != 0);
    localparam int unsigned         DRAIN_W   = $clog2(HALT_DRAIN + 2);
    // The RUN cycle that accepts the halt is the first bubble
    localparam int unsigned         DRAIN_CYC = (HALT_DRAIN > 2) ? HALT_DRAIN - 1 : 1;
    localparam logic [DRAIN_W-1:0]  DRAIN_END = DRAIN_W'(DRAIN_CYC - 1);

    state_e               state_q, state_d;
    logic [TMO_W-1:0]     tmo_q, tmo_d;
    logic [DRAIN_W-1:0]   drain_q, drain_d;
    logic                 halt_pend_q, halt_pend_d;
    logic                 mem_busy;
    logic                 halt_now;
    logic                 wait_out;
    pipe_ctl_t            ctl;
    stage_vec_t           stall_v;
    logic [STG_WB:STG_D]  flush_v;

    assign mem_busy = dmem_req & ~dmem_ready;
    assign halt_now = halt_req | halt_pend_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_RUN;
            tmo_q       <= '0;
            drain_q     <= '0;
            halt_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            tmo_q       <= tmo_d;
            drain_q     <= drain_d;
            halt_pend_q <= halt_pend_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        tmo_d       = tmo_q;
        drain_d     = drain_q;
        halt_pend_d = halt_pend_q | halt_req;
        ctl         = '0;
        wait_out    = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (mem_busy) begin
                    wait_out = 1'b1;
                    state_d  = ST_MEM_WAIT;
                end else if (jump_req) begin
                    ctl.flush[STG_D] = 1'b1;
                    ctl.flush[STG_E] = 1'b1;
                end else if (halt_now) begin
                    ctl.stall[STG_F] = 1'b1;
                    ctl.flush[STG_D] = 1'b1;
                    state_d          = ST_HALT_DRAIN;
                    drain_d          = '0;
                    halt_pend_d      = 1'b0;
                end else if (hz_stall_req) begin
                    ctl.stall[STG_F] = 1'b1;
                    ctl.stall[STG_D] = 1'b1;
                    ctl.flush[STG_E] = 1'b1;
                end
            end
            ST_MEM_WAIT: begin
                if (mem_busy) begin
                    wait_out = 1'b1;
                end else begin
                    state_d = ST_RUN;
                    tmo_d   = '0;
                end
            end
            ST_HALT_DRAIN: begin
                // A memory wait here stalls like MEM_WAIT but keeps the drain position
                halt_pend_d = 1'b0;
                if (mem_busy) begin
                    wait_out = 1'b1;
                end else begin
                    ctl.stall[STG_F] = 1'b1;
                    ctl.flush[STG_D] = 1'b1;
                    tmo_d            = '0;
                    if (drain_q >= DRAIN_END) begin
                        state_d = ST_HALTED;
                    end else begin
                        drain_d = drain_q + DRAIN_W'(1);
                    end
                end
            end
            ST_HALTED: begin
                halt_pend_d = 1'b0;
                ctl.stall   = STALL_ALL;
                if (resume) begin
                    state_d = ST_RUN;
                end
            end
            ST_FAULT: begin
                halt_pend_d = 1'b0;
                ctl.stall   = STALL_ALL;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        if (wait_out) begin
            ctl.stall         = STALL_MEM;
            ctl.flush         = '0;
            ctl.flush[STG_WB] = 1'b1;
            tmo_d             = (&tmo_q) ? tmo_q : tmo_q + TMO_W'(1);
            if (TMO_EN && (state_q != ST_RUN) && (tmo_q == TMO_LIM)) begin
                state_d = ST_FAULT;
            end
        end
    end

    // Controls are gated by reset so nothing leaks while reset_n is low
    assign stall_v = ctl.stall & {NUM_STG{reset_n}};
    assign flush_v = ctl.flush & ~ctl.stall[STG_WB:STG_D] & {(NUM_STG-1){reset_n}};

    assign stall_F  = stall_v[STG_F];
    assign stall_D  = stall_v[STG_D];
    assign stall_E  = stall_v[STG_E];
    assign stall_M  = stall_v[STG_M];
    assign stall_WB = stall_v[STG_WB];
    assign flush_D  = flush_v[STG_D];
    assign flush_E  = flush_v[STG_E];
    assign flush_M  = flush_v[STG_M];
    assign flush_WB = flush_v[STG_WB];
    assign halted   = (state_q == ST_HALTED);
    assign fault    = (state_q == ST_FAULT);
    assign state    = state_q;

`ifdef PIPE_CTRL_PERF_EN
    logic jump_flush;
    assign jump_flush = reset_n & (state_q == ST_RUN) & ~mem_busy & jump_req;

    pipe_ctrl_perf #(
        .CNT_W (CNT_W)
    ) u_perf (
        .clk            (clk),
        .reset_n        (reset_n),
        .stall_f        (stall_F),
        .jump_flush     (jump_flush),
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt)
    );
`else
    // CNT_W only sizes the perf ports; keep it referenced in the plain build
    if (CNT_W == 0) begin : g_no_perf_width
    end
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: per-cycle model compare plus directed
// literal expectations. Perf checks are active when PIPE_CTRL_PERF_EN is defined.
module tb_pipeline_ctrl;

    localparam int HD  = 3;
    localparam int TMO = 8;

    localparam logic [6:0] I_HZ  = 7'b0000001;
    localparam logic [6:0] I_JMP = 7'b0000010;
    localparam logic [6:0] I_REQ = 7'b0000100;
    localparam logic [6:0] I_RDY = 7'b0001000;
    localparam logic [6:0] I_HLT = 7'b0010000;
    localparam logic [6:0] I_RES = 7'b0100000;
    localparam logic [6:0] I_RST = 7'b1000000;

    localparam int M_RUN = 0, M_WAIT = 1, M_DRAIN = 2, M_HALTED = 3, M_FAULT = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic hz_stall_req = 1'b0, jump_req = 1'b0, dmem_req = 1'b0;
    logic dmem_ready = 1'b0, halt_req = 1'b0, resume = 1'b0;
    logic stall_F, stall_D, stall_E, stall_M, stall_WB;
    logic flush_D, flush_E, flush_M, flush_WB;
    logic halted, fault;
    logic [2:0] state;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] perf_stall_cnt, perf_flush_cnt;
`endif

    logic [4:0] d_stall;
    logic [3:0] d_flush;
    assign d_stall = {stall_WB, stall_M, stall_E, stall_D, stall_F};
    assign d_flush = {flush_WB, flush_M, flush_E, flush_D};

    int n_checks = 0;
    int n_fails  = 0;

    pipeline_ctrl #(
        .HALT_DRAIN  (HD),
        .MEM_TIMEOUT (TMO),
        .CNT_W       (32)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .hz_stall_req (hz_stall_req),
        .jump_req     (jump_req),
        .dmem_req     (dmem_req),
        .dmem_ready   (dmem_ready),
        .halt_req     (halt_req),
        .resume       (resume),
        .stall_F      (stall_F),
        .stall_D      (stall_D),
        .stall_E      (stall_E),
        .stall_M      (stall_M),
        .stall_WB     (stall_WB),
        .flush_D      (flush_D),
        .flush_E      (flush_E),
        .flush_M      (flush_M),
        .flush_WB     (flush_WB),
        .halted       (halted),
        .fault        (fault),
        .state        (state)
`ifdef PIPE_CTRL_PERF_EN
        ,
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: mode, consecutive memory-wait streak, drain bubbles left, pending halt
    int   m_mode = 0, m_streak = 0, m_bub = 0;
    bit   m_pend = 0;
    int   n_mode = 0, n_streak = 0, n_bub = 0;
    bit   n_pend = 0;
    logic [4:0] e_stall;
    logic [3:0] e_flush;
    bit   e_jf;
    int unsigned p_stall = 0, p_flush = 0;

    always @(negedge clk) begin
        bit busy;
        busy    = dmem_req && !dmem_ready;
        e_stall = '0;
        e_flush = '0;
        e_jf    = 0;
        n_mode  = m_mode;
        n_streak = busy ? m_streak : 0;
        n_bub   = m_bub;
        n_pend  = m_pend | halt_req;
        if (!reset_n) begin
            n_mode = M_RUN; n_streak = 0; n_bub = 0; n_pend = 0;
        end else begin
            if (m_mode == M_RUN) begin
                if (busy) begin
                    e_stall = 5'b01111; e_flush = 4'b1000;
                    n_mode = M_WAIT; n_streak = 1;
                end else if (jump_req) begin
                    e_flush = 4'b0011; e_jf = 1;
                end else if (halt_req || m_pend) begin
                    e_stall = 5'b00001; e_flush = 4'b0001;
                    n_pend = 0; n_mode = M_DRAIN; n_bub = (HD > 2) ? HD - 1 : 1;
                end else if (hz_stall_req) begin
                    e_stall = 5'b00011; e_flush = 4'b0010;
                end
            end else if (m_mode == M_WAIT || m_mode == M_DRAIN) begin
                if (m_mode == M_DRAIN) n_pend = 0;
                if (busy) begin
                    e_stall = 5'b01111; e_flush = 4'b1000;
                    if (TMO != 0 && m_streak == TMO) n_mode = M_FAULT;
                    else n_streak = m_streak + 1;
                end else if (m_mode == M_WAIT) begin
                    n_mode = M_RUN;
                end else begin
                    e_stall = 5'b00001; e_flush = 4'b0001;
                    n_bub = m_bub - 1;
                    if (n_bub == 0) n_mode = M_HALTED;
                end
            end else begin
                n_pend  = 0;
                e_stall = 5'b11111;
                if (m_mode == M_HALTED && resume) n_mode = M_RUN;
            end
        end
        chk("model.stall",  32'(d_stall), 32'(e_stall));
        chk("model.flush",  32'(d_flush), 32'(e_flush));
        chk("model.state",  32'(state),   reset_n ? 32'(m_mode) : 32'd0);
        chk("model.halted", 32'(halted),  32'(reset_n && m_mode == M_HALTED));
        chk("model.fault",  32'(fault),   32'(reset_n && m_mode == M_FAULT));
`ifdef PIPE_CTRL_PERF_EN
        chk("model.perf_stall", perf_stall_cnt, reset_n ? p_stall : 0);
        chk("model.perf_flush", perf_flush_cnt, reset_n ? p_flush : 0);
`endif
    end

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_mode = M_RUN; m_streak = 0; m_bub = 0; m_pend = 0;
            p_stall = 0; p_flush = 0;
        end else begin
            p_stall += 32'(e_stall[0]);
            p_flush += 32'(e_jf);
            m_mode = n_mode; m_streak = n_streak; m_bub = n_bub; m_pend = n_pend;
        end
    end

    task automatic cyc(input logic [6:0] v);
        @(posedge clk);
        #1;
        reset_n      = ~v[6];
        resume       = v[5];
        halt_req     = v[4];
        dmem_ready   = v[3];
        dmem_req     = v[2];
        jump_req     = v[1];
        hz_stall_req = v[0];
        @(negedge clk);
    endtask

    task automatic lit(input string name, input logic [4:0] s, input logic [3:0] f, input logic [2:0] st);
        chk({name, ".stall"},  32'(d_stall), 32'(s));
        chk({name, ".flush"},  32'(d_flush), 32'(f));
        chk({name, ".state"},  32'(state),   32'(st));
        chk({name, ".halted"}, 32'(halted),  32'(st == 3'd3));
        chk({name, ".fault"},  32'(fault),   32'(st == 3'd4));
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        lit("reset", 5'b00000, 4'b0000, 3'd0);
        cyc('0);

        for (int i = 0; i < 2; i++) begin
            cyc(I_HZ);
            lit("hazard", 5'b00011, 4'b0010, 3'd0);
        end
        cyc('0);
        lit("hazard_end", 5'b00000, 4'b0000, 3'd0);

        cyc(I_HZ | I_JMP);
        lit("jump_over_hz", 5'b00000, 4'b0011, 3'd0);
        cyc('0);
        lit("jump_after", 5'b00000, 4'b0000, 3'd0);

        for (int i = 0; i < 4; i++) begin
            cyc(I_REQ);
            lit("mem_wait", 5'b01111, 4'b1000, (i == 0) ? 3'd0 : 3'd1);
        end
        cyc(I_REQ | I_RDY);
        lit("mem_ready", 5'b00000, 4'b0000, 3'd1);
        cyc('0);
        lit("mem_run", 5'b00000, 4'b0000, 3'd0);

        cyc(I_HLT);
        lit("halt_accept", 5'b00001, 4'b0001, 3'd0);
        for (int i = 0; i < 2; i++) begin
            cyc('0);
            lit("halt_drain", 5'b00001, 4'b0001, 3'd2);
        end
        cyc('0);
        lit("halted", 5'b11111, 4'b0000, 3'd3);
        cyc(I_RES);
        lit("resume_cycle", 5'b11111, 4'b0000, 3'd3);
        cyc('0);
        lit("resumed", 5'b00000, 4'b0000, 3'd0);

        cyc(I_REQ);
        cyc(I_REQ | I_HLT);
        lit("wait_halt", 5'b01111, 4'b1000, 3'd1);
        cyc(I_REQ | I_RDY);
        cyc('0);
        lit("latched_halt", 5'b00001, 4'b0001, 3'd0);
        repeat (3) cyc('0);
        lit("latched_halted", 5'b11111, 4'b0000, 3'd3);
        cyc(I_RES);
        cyc('0);

        cyc(I_JMP | I_HLT);
        lit("jump_over_halt", 5'b00000, 4'b0011, 3'd0);
        cyc('0);
        lit("jump_then_halt", 5'b00001, 4'b0001, 3'd0);
        cyc('0);
        cyc(I_RST);
        lit("reset_mid_drain", 5'b00000, 4'b0000, 3'd0);
        cyc('0);
        lit("after_drain_reset", 5'b00000, 4'b0000, 3'd0);

        for (int i = 0; i < 5; i++) cyc(I_HZ);
        for (int i = 0; i < 2; i++) cyc(I_JMP);
        cyc('0);
`ifdef PIPE_CTRL_PERF_EN
        chk("perf_stall_5", perf_stall_cnt, 32'd5);
        chk("perf_flush_2", perf_flush_cnt, 32'd2);
`endif
        repeat (3) cyc(I_HZ);
        cyc(I_RST | I_HZ);
        lit("reset_mid_count", 5'b00000, 4'b0000, 3'd0);
`ifdef PIPE_CTRL_PERF_EN
        chk("perf_stall_rst", perf_stall_cnt, 32'd0);
        chk("perf_flush_rst", perf_flush_cnt, 32'd0);
`endif
        cyc('0);

        cyc(I_REQ);
        lit("tmo_enter", 5'b01111, 4'b1000, 3'd0);
        for (int i = 0; i < TMO; i++) begin
            cyc(I_REQ);
            lit("tmo_wait", 5'b01111, 4'b1000, 3'd1);
        end
        for (int i = 0; i < 3; i++) begin
            cyc(I_REQ);
            lit("fault", 5'b11111, 4'b0000, 3'd4);
        end
        cyc(I_RST | I_REQ);
        lit("fault_reset", 5'b00000, 4'b0000, 3'd0);
        cyc('0);
        lit("fault_cleared", 5'b00000, 4'b0000, 3'd0);

        cyc(I_REQ);
        cyc(I_REQ);
        cyc(I_RST);
        lit("reset_mid_wait", 5'b00000, 4'b0000, 3'd0);
        cyc('0);
        lit("after_wait_reset", 5'b00000, 4'b0000, 3'd0);
        cyc(I_HZ);
        lit("hazard_after_reset", 5'b00011, 4'b0010, 3'd0);
        cyc('0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
